// File: rtl/pacman_pkg.sv
// Shared Pac-Man sprite types and constants.
// PACMAN_ANIM_PINGPONG_EN selects the 0,1,2,1 mouth cycle.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam int          SPRITE_W_DEF = 16;
  localparam logic [23:0] PAC_RGB      = 24'hFFFF00;
  localparam logic [23:0] BLANK_RGB    = 24'h000000;

`ifdef PACMAN_ANIM_PINGPONG_EN
  localparam logic [1:0] STEP_LAST = 2'd3;
`else
  localparam logic [1:0] STEP_LAST = 2'd2;
`endif

  // Step 3 only exists in the ping-pong build; it folds back to frame 1.
  function automatic logic [1:0] step_to_frame(
    input logic [1:0] step
  );
    return (step == 2'd3) ? 2'd1 : step;
  endfunction

endpackage

// File: rtl/pacman_sprite_renderer_if.sv
// ROM and pixel-output bundle of the Pac-Man renderer.
// master = renderer, slave = frame ROMs plus video mixer.
interface pacman_sprite_renderer_if;
  logic [7:0]  rom_addr;
  logic [11:0] rom_q;
  logic        pix_on;
  logic [23:0] pix_rgb;

  modport master (
    output rom_addr,
    input  rom_q,
    output pix_on,
    output pix_rgb
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    input  pix_on,
    input  pix_rgb
  );
endinterface

// File: rtl/pacman_anim_ctr.sv
// Pac-Man mouth animation: tick divider, step counter, frame latch.
// Step range depends on PACMAN_ANIM_PINGPONG_EN (see pacman_pkg).
module pacman_anim_ctr
  import pacman_pkg::*;
#(
  parameter int ANIM_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       moving,
  output logic [1:0] frame_l
);

  localparam logic [3:0] TICK_LAST = 4'(ANIM_DIV - 1);

  logic [3:0] tick_q, tick_d;
  logic [1:0] step_q, step_d;
  logic [1:0] frame_q, frame_d;

  always_comb begin
    tick_d  = tick_q;
    step_d  = step_q;
    frame_d = frame_q;
    if (frame_tick && moving) begin
      if (tick_q == TICK_LAST) begin
        tick_d = 4'd0;
        step_d = (step_q == STEP_LAST) ? 2'd0
                                       : step_q + 2'd1;
      end else begin
        tick_d = tick_q + 4'd1;
      end
    end
    // Frame follows the new step in the same vblank as dir.
    if (frame_tick) begin
      frame_d = step_to_frame(step_d);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q  <= 4'd0;
      step_q  <= 2'd0;
      frame_q <= 2'd0;
    end else begin
      tick_q  <= tick_d;
      step_q  <= step_d;
      frame_q <= frame_d;
    end
  end

  assign frame_l = frame_q;

endmodule

// File: rtl/pacman_sprite_renderer.sv
// Pac-Man sprite renderer: hit test, ROM address, pixel colour.
// Build with PACMAN_ANIM_PINGPONG_EN for the 0,1,2,1 mouth cycle.
module pacman_sprite_renderer
  import pacman_pkg::*;
#(
  parameter int ANIM_DIV = 4,
  parameter int SPRITE_W = SPRITE_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic [1:0]  dir,
  input  logic        moving,
  output logic [7:0]  rom_addr,
  input  logic [11:0] rom_q,
  output logic        pix_on,
  output logic [23:0] pix_rgb
);

  logic [10:0] dx, dy;
  logic        hit;
  logic        hit_q, hit_d;
  dir_t        dir_l_q, dir_l_d;
  logic [1:0]  frame_l;
  logic [1:0]  dir_bits;
  logic [3:0]  sel_idx;

  pacman_anim_ctr #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .moving     (moving),
    .frame_l    (frame_l)
  );

  // Ordering tests keep coordinates near 1023 from wrapping.
  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, pac_x};
    dy  = {1'b0, draw_y} - {1'b0, pac_y};
    hit = (draw_x >= pac_x) && (dx < 11'(SPRITE_W))
       && (draw_y >= pac_y) && (dy < 11'(SPRITE_W));
    rom_addr = {dy[3:0], dx[3:0]};
  end

  always_comb begin
    hit_d   = hit;
    dir_l_d = dir_l_q;
    if (frame_tick) begin
      dir_l_d = dir_t'(dir);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q   <= 1'b0;
      dir_l_q <= DIR_RIGHT;
    end else begin
      hit_q   <= hit_d;
      dir_l_q <= dir_l_d;
    end
  end

  always_comb begin
    dir_bits = dir_l_q;
    sel_idx  = {1'b0, dir_bits, 1'b0}
             + {2'b00, dir_bits}
             + {2'b00, frame_l};
    pix_on   = hit_q & rom_q[sel_idx];
    pix_rgb  = pix_on ? PAC_RGB : BLANK_RGB;
  end

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// Directed bench for pacman_sprite_renderer.
// Honours PACMAN_ANIM_PINGPONG_EN for the expected frame sequence.
module tb_pacman_sprite_renderer;

  logic       clock      = 1'b0;
  logic       reset      = 1'b1;
  logic       frame_tick = 1'b0;
  logic       moving     = 1'b0;
  logic [9:0] draw_x     = '0;
  logic [9:0] draw_y     = '0;
  logic [9:0] pac_x      = '0;
  logic [9:0] pac_y      = '0;
  logic [1:0] dir        = 2'd0;

  int vecs = 0;
  int errs = 0;

`ifdef PACMAN_ANIM_PINGPONG_EN
  localparam int F12 = 1;
  localparam int F_RESUME = 0;
`else
  localparam int F12 = 0;
  localparam int F_RESUME = 1;
`endif

  int exp_f [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, F12};

  pacman_sprite_renderer_if rif ();

  always #5 clock = ~clock;

  pacman_sprite_renderer #(
    .ANIM_DIV (4),
    .SPRITE_W (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .pac_x      (pac_x),
    .pac_y      (pac_y),
    .dir        (dir),
    .moving     (moving),
    .rom_addr   (rif.rom_addr),
    .rom_q      (rif.rom_q),
    .pix_on     (rif.pix_on),
    .pix_rgb    (rif.pix_rgb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // hit_q must already be 1: only rom_q bit idx may light the pixel.
  task automatic probe(input string tag, input int idx);
    logic [11:0] oh;
    oh = 12'd1 << idx;
    rif.rom_q = oh;
    #1;
    chk({tag, "_sel"}, 32'(rif.pix_on), 32'd1);
    rif.rom_q = ~oh;
    #1;
    chk({tag, "_oth"}, 32'(rif.pix_on), 32'd0);
  endtask

  initial begin
    rif.rom_q = 12'hFFF;
    step();
    step();
    chk("rst_pix_on", 32'(rif.pix_on), 32'd0);
    chk("rst_pix_rgb", 32'(rif.pix_rgb), 32'd0);
    reset = 1'b0;

    // Basic hit at (3,2) inside the sprite.
    pac_x = 10'd100; pac_y = 10'd50;
    draw_x = 10'd103; draw_y = 10'd52;
    rif.rom_q = 12'h001;
    #1;
    chk("addr_23", 32'(rif.rom_addr), 32'h23);
    step();
    chk("hit_pix_on", 32'(rif.pix_on), 32'd1);
    chk("hit_rgb", 32'(rif.pix_rgb), 32'hFFFF00);

    // Edges with all ROM bits set.
    rif.rom_q = 12'hFFF;
    draw_x = 10'd116; draw_y = 10'd50;
    step();
    chk("right_out", 32'(rif.pix_on), 32'd0);
    chk("right_rgb", 32'(rif.pix_rgb), 32'd0);
    draw_x = 10'd99;
    #1;
    chk("addr_left", 32'(rif.rom_addr), 32'h0F);
    step();
    chk("left_out", 32'(rif.pix_on), 32'd0);
    draw_x = 10'd115; draw_y = 10'd65;
    step();
    chk("corner_in", 32'(rif.pix_on), 32'd1);
    draw_x = 10'd100; draw_y = 10'd66;
    step();
    chk("below_out", 32'(rif.pix_on), 32'd0);

    // No wrap-around near 1023.
    pac_x = 10'd1020; pac_y = 10'd1020;
    draw_x = 10'd2; draw_y = 10'd2;
    step();
    chk("nowrap_out", 32'(rif.pix_on), 32'd0);
    draw_x = 10'd1023; draw_y = 10'd1023;
    step();
    chk("edge1023_in", 32'(rif.pix_on), 32'd1);

    // Animation: 12 moving ticks facing right.
    pac_x = 10'd100; pac_y = 10'd50;
    draw_x = 10'd103; draw_y = 10'd52;
    moving = 1'b1;
    step();
    probe("frame_init", 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      probe($sformatf("anim_t%0d", k + 1), exp_f[k]);
    end

    // Direction change mid-frame waits for frame_tick.
    dir = 2'd2;
    step();
    probe("dir_hold", F12);
    tick();
    probe("dir_up", 6 + F12);

    // Held animation while stopped.
    moving = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    probe("stop_hold", 6 + F12);

    // Resume: divider was at 1, so third tick wraps.
    moving = 1'b1;
    tick();
    tick();
    probe("resume_pre", 6 + F12);
    tick();
    probe("resume_wrap", 6 + F_RESUME);

    // Reset wins over a coincident frame_tick.
    rif.rom_q = 12'hFFF;
    dir = 2'd3;
    reset = 1'b1;
    frame_tick = 1'b1;
    step();
    reset = 1'b0;
    frame_tick = 1'b0;
    chk("rst_tick_pix", 32'(rif.pix_on), 32'd0);
    chk("rst_tick_rgb", 32'(rif.pix_rgb), 32'd0);
    step();
    probe("rst_dir_frame", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pacman_sprite_renderer.md
PACMAN_SPRITE_RENDERER -- requirements
Module: pacman_sprite_renderer

Interface
REQ-001 SHALL have parameter ANIM_DIV, default 4: frame_tick pulses per animation step, legal range 1..15.
REQ-002 SHALL have parameter SPRITE_W, default 16: sprite edge in pixels; rom_addr = {dy[3:0], dx[3:0]}.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port frame_tick, input, 1 bit: one-cycle pulse once per video frame, at vertical blank.
REQ-006 SHALL have ports draw_x and draw_y, input, 10 bits each: current pixel coordinate.
REQ-007 SHALL have ports pac_x and pac_y, input, 10 bits each: sprite top-left corner.
REQ-008 SHALL have port dir, input, 2 bits: 00 right, 01 left, 10 up, 11 down.
REQ-009 SHALL have port moving, input, 1 bit: high while Pac-Man is advancing.
REQ-010 SHALL have port rom_addr, output, 8 bits: address shared by all twelve Pac-Man frame ROMs.
REQ-011 SHALL have port rom_q, input, 12 bits: 1-bit ROM outputs, bit index = dir*3 + frame (frame 0..2 = sprite _1.._3).
REQ-012 SHALL have port pix_on, output, 1 bit: Pac-Man covers the pixel issued one cycle earlier.
REQ-013 SHALL have port pix_rgb, output, 24 bits: pixel colour; meaningful only when pix_on=1.

Function
REQ-014 SHALL compute dx = draw_x - pac_x and dy = draw_y - pac_y in 11 bits; hit = (draw_x >= pac_x) && (dx < SPRITE_W) && (draw_y >= pac_y) && (dy < SPRITE_W).
REQ-015 SHALL drive rom_addr combinationally from dx[3:0], dy[3:0] for every draw coordinate, including off-sprite ones.
REQ-016 SHALL register hit into hit_q each cycle to match the 1-cycle synchronous ROM read.
REQ-017 SHALL drive pix_on = hit_q & rom_q[dir_l*3 + frame_l]; latency from draw_x/draw_y to pix_on is exactly 1 cycle.
REQ-018 SHALL drive pix_rgb = 24'hFFFF00 when pix_on=1, else 24'h000000.
REQ-019 SHALL latch dir into dir_l only on frame_tick, so the sprite never tears mid-frame; a dir change coincident with frame_tick is latched in that cycle.
REQ-020 SHALL use a tick counter 0..ANIM_DIV-1 advancing on frame_tick while moving=1; on wrap to 0 the step counter advances.
REQ-021 SHALL hold the tick counter, the step counter and frame_l while moving=0; animation resumes from the held values.
REQ-022 SHALL update frame_l from the step counter only on frame_tick, coincident with dir_l.
REQ-023 SHALL, with ANIM_DIV=1, advance one step on every frame_tick while moving=1.
REQ-024 SHALL place no constraint on pac_x/pac_y near 1023; no wrap-around hits (REQ-014 comparisons are unsigned, non-wrapping).

Reset
REQ-025 SHALL on reset set tick counter=0, step=0, frame_l=0, dir_l=right, hit_q=0; hence pix_on=0 and pix_rgb=0 in the following cycle.
REQ-026 SHALL give reset priority over a coincident frame_tick; reset mid-frame aborts animation and takes effect at the next edge.

Configuration
REQ-027 SHALL, with PACMAN_ANIM_PINGPONG_EN defined, use a 4-state step counter mapping to frame sequence 0,1,2,1,0,...
REQ-028 SHALL, without PACMAN_ANIM_PINGPONG_EN defined, use a 3-state step counter mapping to frame sequence 0,1,2,0,...

Structure
REQ-029 SHALL take dir_t enum, SPRITE_W default and PAC_RGB constant from shared package pacman_pkg.
REQ-030 SHALL implement the tick counter, step counter and frame mapping in sub-module pacman_anim_ctr; address, hit and output logic stay in the top module.

Verification
REQ-031 SHALL verify: pac=(100,50), draw=(103,52), rom_q[0]=1 -> rom_addr=8'h23, pix_on=1, pix_rgb=FFFF00 one cycle later.
REQ-032 SHALL verify: draw=(116,50) or (99,50) with pac=(100,50) and rom_q all ones -> pix_on=0 next cycle.
REQ-033 SHALL verify: moving=1, ANIM_DIV=4, 12 frame_ticks -> frame_l changes after ticks 4, 8, 12; pingpong build gives 1,2,1; plain build gives 1,2,0.
REQ-034 SHALL verify: dir changes from right to up mid-frame -> selected bit stays rom_q[frame_l] until frame_tick, then becomes rom_q[6+frame_l].
REQ-035 SHALL verify: moving=0 for 10 ticks -> frame_l unchanged; reset asserted on a frame_tick -> frame_l=0, dir_l=right, pix_on=0 next cycle.
